spi_xfer: RTL

SPI_XFER -- requirements
Module: spi_xfer

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_div.sv | 26 ++
 rtl/spi_xfer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared constants for the SPI transfer engine: FSM encoding and the cfg/stat word map.
package spi_pkg;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SETUP    = 3'd1;
  localparam logic [2:0] S_SHIFT_HI = 3'd2;
  localparam logic [2:0] S_SHIFT_LO = 3'd3;
  localparam logic [2:0] S_HOLD     = 3'd4;

  localparam int TX_BASE   = 1;
  localparam int STAT_WORD = 6;
  localparam int DIV_WORD  = 7;
  localparam int MAX_WORDS = 6;

  function automatic logic [15:0] cfg_word(input logic [127:0] bus, input int idx);
    return bus[16*idx +: 16];
  endfunction

endpackage

// File: rtl/spi_div.sv
// Loadable down-counter that times one SPI phase; tick_o is high on the last cycle of the phase.
module spi_div #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tick_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/spi_xfer.sv
// Mode-0 SPI master moving up to six 16-bit words per GO toggle, configured through the reg-file banks.
//   state      | meaning
//   S_IDLE     | cs_n high, waiting for GO != ACK
//   S_SETUP    | cs_n low, first MSB on mosi before the first rising sclk
//   S_SHIFT_HI | sclk high; miso captured on entry
//   S_SHIFT_LO | sclk low; mosi advanced on entry
//   S_HOLD     | cs_n still low after the last bit, then release
module spi_xfer
  import spi_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] cfg,
  output logic [127:0] stat,
  output logic         sclk,
  output logic         mosi,
  input  logic         miso,
  output logic         cs_n
);

  logic [2:0]       state_q, state_d;
  logic             ack_q, ack_d;
  logic [7:0]       done_q, done_d;
  logic [2:0]       len_q, len_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [15:0]      tx_q [MAX_WORDS];
  logic [15:0]      tx_d [MAX_WORDS];
  logic [15:0]      rx_q [MAX_WORDS];
  logic [15:0]      rx_d [MAX_WORDS];
  logic [15:0]      sr_q, sr_d;
  logic [6:0]       bit_q, bit_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             cs_n_q, cs_n_d;

  logic             go, start, tick, phase_end, do_sample, do_shift, last_bit;
  logic [2:0]       len_cfg;
  logic [6:0]       nbits;
  logic [15:0]      sr_next;
  logic [DIV_W-1:0] div_cfg, div_load_val;
  logic             unused_cfg;

  assign go           = cfg[0];
  assign len_cfg      = (cfg[3:1] > 3'(MAX_WORDS-1)) ? 3'(MAX_WORDS-1) : cfg[3:1];
  assign div_cfg      = cfg[16*DIV_WORD +: DIV_W];
  assign unused_cfg   = ^{cfg[15:4], cfg[127:112]};
  assign nbits        = {len_q + 3'd1, 4'b0000};
  assign last_bit     = (bit_q == nbits);
  assign phase_end    = tick && (state_q != S_IDLE);
  assign sr_next      = {sr_q[14:0], miso};
  assign div_load_val = start ? div_cfg : div_q;

  spi_div #(.W(DIV_W)) u_div (
    .clk        (clk),
    .rst        (rst),
    .load_i     (start | phase_end),
    .load_val_i (div_load_val),
    .tick_o     (tick)
  );

  always_comb begin
    state_d   = state_q;
    ack_d     = ack_q;
    done_d    = done_q;
    len_d     = len_q;
    div_d     = div_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    sr_d      = sr_q;
    bit_d     = bit_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    start     = 1'b0;
    do_sample = 1'b0;
    do_shift  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (go != ack_q) begin
          start   = 1'b1;
          state_d = S_SETUP;
          ack_d   = go;
          len_d   = len_cfg;
          div_d   = div_cfg;
          for (int k = 0; k < MAX_WORDS; k++) tx_d[k] = cfg_word(cfg, TX_BASE + k);
          bit_d   = '0;
          cs_n_d  = 1'b0;
          mosi_d  = cfg[16*TX_BASE + 15];
        end
      end
      S_SETUP: begin
        if (phase_end) begin
          state_d   = S_SHIFT_HI;
          sclk_d    = 1'b1;
          do_sample = 1'b1;
        end
      end
      S_SHIFT_HI: begin
        if (phase_end) begin
          state_d  = S_SHIFT_LO;
          sclk_d   = 1'b0;
          do_shift = 1'b1;
        end
      end
      S_SHIFT_LO: begin
        if (phase_end) begin
          if (last_bit) begin
            state_d = S_HOLD;
          end else begin
            state_d   = S_SHIFT_HI;
            sclk_d    = 1'b1;
            do_sample = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (phase_end) begin
          state_d = S_IDLE;
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
          done_d  = done_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        sclk_d  = 1'b0;
        cs_n_d  = 1'b1;
        mosi_d  = 1'b0;
      end
    endcase

    // bit_q counts captured bits, so it also indexes the next bit to drive
    if (do_sample) begin
      sr_d  = sr_next;
      bit_d = bit_q + 7'd1;
      if (bit_q[3:0] == 4'hF) begin
        for (int k = 0; k < MAX_WORDS; k++) begin
          if (bit_q[6:4] == 3'(k)) rx_d[k] = sr_next;
        end
      end
    end

    if (do_shift) begin
      mosi_d = 1'b0;
      for (int k = 0; k < MAX_WORDS; k++) begin
        if ((bit_q[6:4] == 3'(k)) && !last_bit) mosi_d = tx_q[k][~bit_q[3:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      done_q  <= '0;
      len_q   <= '0;
      div_q   <= '0;
      sr_q    <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      for (int k = 0; k < MAX_WORDS; k++) begin
        tx_q[k] <= '0;
        rx_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      len_q   <= len_d;
      div_q   <= div_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
    end
  end

  always_comb begin
    stat = '0;
    for (int k = 0; k < MAX_WORDS; k++) stat[16*k +: 16] = rx_q[k];
    stat[16*STAT_WORD +: 16] = {done_q, 6'b000000, ack_q, state_q != S_IDLE};
  end

  assign sclk = sclk_q;
  assign mosi = mosi_q;
  assign cs_n = cs_n_q;

endmodule
